// File: rtl/maindec_pkg.sv
// Shared types and constants for the multicycle LEGv8 main decoder.
// Opcodes are matched as value/care pairs so partial fields (CBZ, B) share one helper.
package maindec_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, ERR} state_t;
  typedef enum logic [2:0] {CL_ILL, CL_LDUR, CL_STUR, CL_CBZ, CL_RTYPE, CL_IMM, CL_B} cls_t;

  localparam logic [1:0] ALU_MEM = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;

  localparam logic [10:0] CARE_ALL = 11'b111_1111_1111;

  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] CARE_CBZ = 11'b11111111000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_ADDI  = 11'b10010001000;
  localparam logic [10:0] OP_SUBI  = 11'b11010001000;
  localparam logic [10:0] CARE_IMM = 11'b11111111110;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] CARE_B   = 11'b11111100000;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                    input logic [10:0] care);
    return ((op ^ val) & care) == 11'd0;
  endfunction

endpackage

// File: rtl/maindec_mc_opclass.sv
// Combinational opcode classifier. MAINDEC_MC_EXT_EN adds ADDI/SUBI, B and CBNZ;
// without it those encodings fall through to CL_ILL.
module opclass
  import maindec_pkg::*;
(
  input  logic [10:0] i_op,
  output cls_t        o_cls,
  output logic        o_ill
);

  always_comb begin
    o_cls = CL_ILL;
    if (op_match(i_op, OP_LDUR, CARE_ALL))                 o_cls = CL_LDUR;
    else if (op_match(i_op, OP_STUR, CARE_ALL))            o_cls = CL_STUR;
    else if (op_match(i_op, OP_CBZ, CARE_CBZ))             o_cls = CL_CBZ;
    else if (op_match(i_op, OP_ADD, CARE_ALL) || op_match(i_op, OP_SUB, CARE_ALL) ||
             op_match(i_op, OP_AND, CARE_ALL) || op_match(i_op, OP_ORR, CARE_ALL))
                                                           o_cls = CL_RTYPE;
`ifdef MAINDEC_MC_EXT_EN
    else if (op_match(i_op, OP_CBNZ, CARE_CBZ))            o_cls = CL_CBZ;
    else if (op_match(i_op, OP_ADDI, CARE_IMM) || op_match(i_op, OP_SUBI, CARE_IMM))
                                                           o_cls = CL_IMM;
    else if (op_match(i_op, OP_B, CARE_B))                 o_cls = CL_B;
`endif
    o_ill = (o_cls == CL_ILL);
  end

endmodule

// File: rtl/maindec_mc.sv
// Multicycle Moore main decoder with retired-instruction counter and sticky illegal flag.
// MAINDEC_MC_EXT_EN enables ADDI/SUBI, B and CBNZ.
module maindec_mc
  import maindec_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      Op,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             UncondBranch,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [1:0]       ALUOp,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t           r_state, w_nxt;
  logic [10:0]      r_op_q;
  logic             r_ill;
  logic [CNT_W-1:0] r_cnt;
  logic [10:0]      w_cls_op;
  cls_t             w_cls;
  logic             w_ill;

  // In DECODE classify the live opcode; afterwards the latched one drives the outputs.
  assign w_cls_op = (r_state == DECODE) ? Op : r_op_q;

  opclass u_opclass (
    .i_op  (w_cls_op),
    .o_cls (w_cls),
    .o_ill (w_ill)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= FETCH;
    else          r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_q <= '0;
      r_ill  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_state == DECODE) r_op_q <= Op;
      if (r_state == DECODE && w_ill) r_ill <= 1'b1;
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, retire};
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      FETCH:  if (imem_ready) w_nxt = DECODE;
      DECODE: w_nxt = w_ill ? ERR : EXEC;
      EXEC: begin
        case (w_cls)
          CL_LDUR, CL_STUR: w_nxt = MEM;
          CL_RTYPE, CL_IMM: w_nxt = WB;
          default:          w_nxt = FETCH;
        endcase
      end
      MEM:    if (dmem_ready) w_nxt = (w_cls == CL_LDUR) ? WB : FETCH;
      WB:     w_nxt = FETCH;
      ERR:    w_nxt = ERR;
      default: w_nxt = FETCH;
    endcase
  end

  always_comb begin
    Reg2Loc      = 1'b0;
    ALUSrc       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    Branch       = 1'b0;
    UncondBranch = 1'b0;
    PCWrite      = 1'b0;
    IRWrite      = 1'b0;
    ALUOp        = 2'b00;
    retire       = 1'b0;
    // Controls are forced low for the whole time reset is held, not just at the edge.
    if (reset_n) begin
      if (r_state == FETCH) begin
        IRWrite = imem_ready;
        PCWrite = imem_ready;
      end
      if ((r_state == EXEC || r_state == MEM || r_state == WB) && !w_ill) begin
        case (w_cls)
          CL_LDUR, CL_STUR: begin
            ALUSrc  = 1'b1;
            ALUOp   = ALU_MEM;
            Reg2Loc = (w_cls == CL_STUR);
          end
          CL_RTYPE: ALUOp = ALU_R;
          CL_IMM: begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_R;
          end
          CL_CBZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = ALU_BR;
          end
          default: ;
        endcase
        case (r_state)
          EXEC: begin
            Branch = (w_cls == CL_CBZ);
`ifdef MAINDEC_MC_EXT_EN
            UncondBranch = (w_cls == CL_B);
`endif
            retire = (w_cls == CL_CBZ) || (w_cls == CL_B);
          end
          MEM: begin
            MemRead  = (w_cls == CL_LDUR);
            MemWrite = (w_cls == CL_STUR);
            retire   = (w_cls == CL_STUR) && dmem_ready;
          end
          WB: begin
            RegWrite = 1'b1;
            MemtoReg = (w_cls == CL_LDUR);
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign illegal     = r_ill;
  assign retired_cnt = r_cnt;

endmodule

// File: tb/tb_maindec_mc.sv
// Self-checking bench for maindec_mc (CNT_W=8); retire-time controls checked via a scoreboard.
module tb_maindec_mc;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [10:0] Op = '0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic       UncondBranch, PCWrite, IRWrite, retire, illegal;
  logic [1:0] ALUOp;
  logic [7:0] retired_cnt;

  int checks = 0;
  int errors = 0;
  logic [12:0] sb_q[$];

  maindec_mc #(.CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .UncondBranch(UncondBranch),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUOp(ALUOp), .retire(retire),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // layout: r2l alus m2r rw mr mw br ub pcw irw aluop[1:0] ret
  localparam logic [12:0] V_ZERO   = 13'b0_0_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_FETCH  = 13'b0_0_0_0_0_0_0_0_1_1_00_0;
  localparam logic [12:0] V_LD_EX  = 13'b0_1_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_LD_MEM = 13'b0_1_0_0_1_0_0_0_0_0_00_0;
  localparam logic [12:0] V_LD_WB  = 13'b0_1_1_1_0_0_0_0_0_0_00_1;
  localparam logic [12:0] V_ST_EX  = 13'b1_1_0_0_0_0_0_0_0_0_00_0;
  localparam logic [12:0] V_ST_MEM = 13'b1_1_0_0_0_1_0_0_0_0_00_0;
  localparam logic [12:0] V_ST_RET = 13'b1_1_0_0_0_1_0_0_0_0_00_1;
  localparam logic [12:0] V_ADD_EX = 13'b0_0_0_0_0_0_0_0_0_0_10_0;
  localparam logic [12:0] V_ADD_WB = 13'b0_0_0_1_0_0_0_0_0_0_10_1;
  localparam logic [12:0] V_CBZ_EX = 13'b1_0_0_0_0_0_1_0_0_0_01_1;
`ifdef MAINDEC_MC_EXT_EN
  localparam logic [12:0] V_IMM_EX = 13'b0_1_0_0_0_0_0_0_0_0_10_0;
  localparam logic [12:0] V_IMM_WB = 13'b0_1_0_1_0_0_0_0_0_0_10_1;
  localparam logic [12:0] V_B_EX   = 13'b0_0_0_0_0_0_0_1_0_0_00_1;
`endif

  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BAD  = 11'b11111111111;
  localparam logic [10:0] ADDI = 11'b10010001000;

  function automatic logic [12:0] ctl();
    return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch,
            PCWrite, IRWrite, ALUOp, retire};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset_n && retire) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_retire got %b want no retire", ctl());
      end else begin
        logic [12:0] exp;
        exp = sb_q.pop_front();
        if (ctl() !== exp) begin
          errors++;
          $display("FAIL sb_retire_ctl got %b want %b", ctl(), exp);
        end
      end
    end
  end

  task automatic test_reset();
    step(); imem_ready = 1'b1; #1;
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL reset_ctl got %b want %b", ctl(), V_ZERO); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    checks++; if (retired_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", retired_cnt); end
    imem_ready = 1'b0; reset_n = 1'b1;
    step(); #1;
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL fetch_idle got %b want %b", ctl(), V_ZERO); end
  endtask

  task automatic test_ldur();
    int mr_cycles = 0;
    step(); imem_ready = 1'b1; Op = LDUR; sb_q.push_back(V_LD_WB); #1;
    checks++; if (ctl() !== V_FETCH) begin errors++; $display("FAIL ldur_fetch got %b want %b", ctl(), V_FETCH); end
    step(); imem_ready = 1'b0; #1;
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL ldur_decode got %b want %b", ctl(), V_ZERO); end
    step(); #1;
    checks++; if (ctl() !== V_LD_EX) begin errors++; $display("FAIL ldur_exec got %b want %b", ctl(), V_LD_EX); end
    for (int i = 0; i < 4; i++) begin
      step(); dmem_ready = (i == 3); #1;
      if (MemRead === 1'b1) mr_cycles++;
      checks++; if (ctl() !== V_LD_MEM) begin errors++; $display("FAIL ldur_mem%0d got %b want %b", i, ctl(), V_LD_MEM); end
    end
    checks++; if (mr_cycles != 4) begin errors++; $display("FAIL ldur_memread_len got %0d want 4", mr_cycles); end
    step(); dmem_ready = 1'b0; #1;
    checks++; if (ctl() !== V_LD_WB) begin errors++; $display("FAIL ldur_wb got %b want %b", ctl(), V_LD_WB); end
    checks++; if (retired_cnt !== 8'd0) begin errors++; $display("FAIL ldur_cnt_pre got %0d want 0", retired_cnt); end
    step(); #1;
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL ldur_back_fetch got %b want %b", ctl(), V_ZERO); end
    checks++; if (retired_cnt !== 8'd1) begin errors++; $display("FAIL ldur_cnt got %0d want 1", retired_cnt); end
  endtask

  task automatic test_stur_add();
    step(); imem_ready = 1'b1; Op = STUR; sb_q.push_back(V_ST_RET); #1;
    checks++; if (ctl() !== V_FETCH) begin errors++; $display("FAIL stur_fetch got %b want %b", ctl(), V_FETCH); end
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (ctl() !== V_ST_EX) begin errors++; $display("FAIL stur_exec got %b want %b", ctl(), V_ST_EX); end
    step(); #1;
    checks++; if (ctl() !== V_ST_MEM) begin errors++; $display("FAIL stur_mem_wait got %b want %b", ctl(), V_ST_MEM); end
    step(); dmem_ready = 1'b1; #1;
    checks++; if (ctl() !== V_ST_RET) begin errors++; $display("FAIL stur_mem_ret got %b want %b", ctl(), V_ST_RET); end
    step(); dmem_ready = 1'b0; imem_ready = 1'b1; Op = ADD; sb_q.push_back(V_ADD_WB); #1;
    checks++; if (ctl() !== V_FETCH) begin errors++; $display("FAIL add_fetch got %b want %b", ctl(), V_FETCH); end
    checks++; if (retired_cnt !== 8'd2) begin errors++; $display("FAIL stur_cnt got %0d want 2", retired_cnt); end
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (ctl() !== V_ADD_EX) begin errors++; $display("FAIL add_exec got %b want %b", ctl(), V_ADD_EX); end
    step(); #1;
    checks++; if (ctl() !== V_ADD_WB) begin errors++; $display("FAIL add_wb got %b want %b", ctl(), V_ADD_WB); end
    step(); #1;
    checks++; if (retired_cnt !== 8'd3) begin errors++; $display("FAIL add_cnt got %0d want 3", retired_cnt); end
  endtask

  task automatic test_cbz();
    step(); imem_ready = 1'b1; Op = CBZ; sb_q.push_back(V_CBZ_EX);
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (ctl() !== V_CBZ_EX) begin errors++; $display("FAIL cbz_exec got %b want %b", ctl(), V_CBZ_EX); end
    step(); #1;
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL cbz_next got %b want %b", ctl(), V_ZERO); end
    imem_ready = 1'b1; #1;
    checks++; if (ctl() !== V_FETCH) begin errors++; $display("FAIL cbz_next_fetch got %b want %b", ctl(), V_FETCH); end
    imem_ready = 1'b0;
    checks++; if (retired_cnt !== 8'd4) begin errors++; $display("FAIL cbz_cnt got %0d want 4", retired_cnt); end
  endtask

  task automatic test_async_reset();
    step(); imem_ready = 1'b1; Op = LDUR;
    step(); imem_ready = 1'b0;
    step();
    step(); #1;
    checks++; if (MemRead !== 1'b1) begin errors++; $display("FAIL arst_mem_pre got %b want 1", MemRead); end
    #1 reset_n = 1'b0; #1;
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL arst_memread got %b want 0", MemRead); end
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL arst_ctl got %b want %b", ctl(), V_ZERO); end
    checks++; if (retired_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", retired_cnt); end
    step(); reset_n = 1'b1;
    step(); imem_ready = 1'b1; #1;
    checks++; if (ctl() !== V_FETCH) begin errors++; $display("FAIL arst_refetch got %b want %b", ctl(), V_FETCH); end
    imem_ready = 1'b0;
  endtask

  task automatic test_illegal();
    step(); imem_ready = 1'b1; Op = BAD;
    step(); #1;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_decode got %b want 0", illegal); end
    step(); #1;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_set got %b want 1", illegal); end
    for (int i = 0; i < 20; i++) begin
      step(); #1;
      checks++;
      if (ctl() !== V_ZERO || illegal !== 1'b1) begin
        errors++; $display("FAIL ill_hold%0d got %b/%b want %b/1", i, ctl(), illegal, V_ZERO);
      end
    end
    reset_n = 1'b0; imem_ready = 1'b0; #1;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", illegal); end
    step(); reset_n = 1'b1;
  endtask

  task automatic test_ext();
`ifdef MAINDEC_MC_EXT_EN
    step(); imem_ready = 1'b1; Op = ADDI; sb_q.push_back(V_IMM_WB);
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (ctl() !== V_IMM_EX) begin errors++; $display("FAIL addi_exec got %b want %b", ctl(), V_IMM_EX); end
    step(); #1;
    checks++; if (ctl() !== V_IMM_WB) begin errors++; $display("FAIL addi_wb got %b want %b", ctl(), V_IMM_WB); end
    step(); imem_ready = 1'b1; Op = 11'b00010100000; sb_q.push_back(V_B_EX);
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (ctl() !== V_B_EX) begin errors++; $display("FAIL b_exec got %b want %b", ctl(), V_B_EX); end
    step(); #1;
    checks++; if (retired_cnt !== 8'd2) begin errors++; $display("FAIL ext_cnt got %0d want 2", retired_cnt); end
`else
    step(); imem_ready = 1'b1; Op = ADDI;
    step(); imem_ready = 1'b0;
    step(); #1;
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL addi_illegal got %b want 1", illegal); end
    checks++; if (ctl() !== V_ZERO) begin errors++; $display("FAIL addi_err_ctl got %b want %b", ctl(), V_ZERO); end
`endif
    step(); reset_n = 1'b0;
    step(); reset_n = 1'b1;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      step(); imem_ready = 1'b1; Op = ADD; sb_q.push_back(V_ADD_WB);
      step(); imem_ready = 1'b0;
      step();
      step(); #1;
      if (i == 255) begin
        checks++; if (retired_cnt !== 8'd255) begin errors++; $display("FAIL wrap_pre got %0d want 255", retired_cnt); end
      end
    end
    step(); #1;
    checks++; if (retired_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d want 0", retired_cnt); end
  endtask

  initial begin
    test_reset();
    test_ldur();
    test_stur_add();
    test_cbz();
    test_async_reset();
    test_illegal();
    test_ext();
    test_wrap();
    step(); #1;
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/maindec_mc.md
MAINDEC_MC -- requirements
Module: maindec_mc

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter (legal range 8..64).
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have the port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have the port Op, input, 11 bits: instruction opcode bits [31:21], valid while IRWrite data is held.
REQ-005 SHALL have the ports imem_ready and dmem_ready, input, 1 bit each: memory completion strobes.
REQ-006 SHALL have the ports Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, UncondBranch, PCWrite and IRWrite, output, 1 bit each: datapath controls.
REQ-007 SHALL have the port ALUOp, output, 2 bits: ALU-decoder class.
REQ-008 SHALL have the ports retire, output, 1 bit (one-cycle pulse per completed instruction), and illegal, output, 1 bit (sticky).
REQ-009 SHALL have the port retired_cnt, output, CNT_W bits: the count of retired instructions.

Function
REQ-010 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and ERR, with outputs decoded from the state and the latched opcode op_q only (Moore).
REQ-011 FETCH SHALL assert IRWrite=PCWrite=imem_ready, go to DECODE when imem_ready=1, and otherwise hold with all other outputs 0.
REQ-012 DECODE SHALL latch Op into op_q, go to ERR (setting illegal=1) if the opcode is unsupported, and otherwise go to EXEC.
REQ-013 The supported opcodes SHALL be: LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-014 EXEC SHALL drive the following and transition as listed:
- LDUR/STUR: ALUSrc=1, ALUOp=00, Reg2Loc=STUR, then MEM.
- R-type: ALUOp=10, then WB.
- CBZ: Reg2Loc=1, ALUOp=01, Branch=1, retire, then FETCH.
REQ-015 MEM SHALL assert MemRead (LDUR) or MemWrite (STUR) and hold until dmem_ready=1, then go to WB for LDUR, or to FETCH with retire for STUR.
REQ-016 WB SHALL assert RegWrite=1, MemtoReg=1 for LDUR, retire=1, then go to FETCH.
REQ-017 ERR SHALL drive all controls 0 and be left only by reset.
REQ-018 retired_cnt SHALL increment by 1 in the cycle after each retire pulse and wrap from 2^CNT_W-1 to 0.
REQ-019 ALUSrc, ALUOp and Reg2Loc SHALL be held stable through MEM and WB for the latched instruction.

Reset
REQ-020 Asserting reset_n=0 SHALL immediately force state=FETCH, op_q=0, illegal=0 and retired_cnt=0, with every control output 0, regardless of the state at the time (including mid-MEM).
REQ-021 The first FETCH SHALL begin in the first clock edge after reset_n deasserts.

Configuration
REQ-022 With MAINDEC_MC_EXT_EN defined, the block SHALL additionally support the following:
- ADDI 1001000100x and SUBI 1101000100x: EXEC drives ALUSrc=1, ALUOp=10, then WB.
- B 000101xxxxx: EXEC drives UncondBranch=1, retire, then FETCH.
- CBNZ 10110101xxx: behaves as CBZ.
REQ-023 Without MAINDEC_MC_EXT_EN, these opcodes SHALL be illegal and UncondBranch SHALL be tied to 0.

Structure
REQ-024 A package maindec_pkg SHALL hold the state enum, the opcode constants/casez patterns and the ALUOp class constants.
REQ-025 A combinational sub-module opclass SHALL map the 11-bit opcode to a instruction-class enum and an illegal flag; the FSM, counter and output decode SHALL live in maindec_mc.

Verification
REQ-026 LDUR (Op=11111000010) with imem_ready=1 and dmem_ready delayed 3 cycles -> FETCH, DECODE, EXEC, MEM×4, WB; MemRead held 4 cycles; RegWrite=MemtoReg=1 in WB; retired_cnt 0->1.
REQ-027 STUR followed by ADD -> STUR retires in MEM with MemWrite=1 and Reg2Loc=1; ADD shows ALUOp=10 and RegWrite=1 in WB; retired_cnt=2.
REQ-028 CBZ (Op=10110100101) -> EXEC has Branch=1, ALUOp=01, Reg2Loc=1, retire=1; the next state is FETCH.
REQ-029 Op=11111111111 -> illegal=1 from DECODE+1; outputs stay 0 for 20 cycles despite imem_ready=1; reset_n pulse clears illegal.
REQ-030 reset_n=0 asserted asynchronously mid-MEM -> MemRead drops before the next clk edge; retired_cnt=0; FETCH restarts after release.
REQ-031 With CNT_W=8, 256 retired ADDs -> retired_cnt wraps to 0; with EXT_EN, ADDI gives ALUSrc=1, and without EXT_EN it gives illegal=1.
